branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PHT_DEPTH, default 256, number of 2-bit counters (power of two, 16..1024); IDX_W = log2(PHT_DEPTH).
REQ-002 SHALL have parameter GHR_W, default 8, global history width (1..IDX_W).
REQ-003 SHALL have parameter MODE, default 1, predictor mode: 0 = static not-taken, 1 = bimodal, 2 = gshare.
REQ-004 SHALL have ports, in order:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous, active-high reset
pcF  in  32  fetch PC to look up
lookup_en  in  1  capture lookup (driven ~stallD)
flushD  in  1  clear D-stage prediction outputs
branchD  in  1  instruction in D is a conditional branch
resolve_valid  in  1  branch resolved in E this cycle
resolve_idx  in  IDX_W  index carried with the resolving branch
resolve_ghr  in  GHR_W  history snapshot carried with the resolving branch
resolve_take  in  1  actual outcome, 1 = taken
resolve_mispredict  in  1  predicted direction was wrong
ready  out  1  table initialised, predictions valid
pred_takeD  out  1  predicted direction for D
pred_idxD  out  IDX_W  table index used for pred_takeD
pred_ghrD  out  GHR_W  history used for pred_takeD

Function
REQ-005 SHALL have a two-state FSM: INIT and RUN.
REQ-006 INIT SHALL write 2'b01 (weakly not-taken) to one counter per cycle, index 0 upward, then enter RUN after index PHT_DEPTH-1 is written.
REQ-007 ready SHALL be 0 in INIT and 1 in RUN.
REQ-008 In INIT: resolve inputs SHALL be ignored; pred_takeD SHALL be forced 0; GHR SHALL hold 0.
REQ-009 Lookup index SHALL be:
- MODE 1: pcF[IDX_W+1:2]
- MODE 2: pcF[IDX_W+1:2] XOR zero-extended GHR
- MODE 0: 0
REQ-010 Lookup SHALL be registered with a latency of one cycle: when lookup_en=1 at edge t, pred_takeD, pred_idxD and pred_ghrD SHALL reflect pcF and GHR sampled at t.
REQ-011 pred_takeD SHALL equal bit 1 of the indexed counter in MODE 1/2 and SHALL always be 0 in MODE 0.
REQ-012 When lookup_en=0 and flushD=0, all D outputs SHALL hold their values.
REQ-013 flushD=1 SHALL clear pred_takeD, pred_idxD and pred_ghrD to 0 at the next edge; flushD SHALL have priority over lookup_en.
REQ-014 Counter update on resolve_valid in RUN SHALL saturate:
- taken: increment, 2'b11 holds
- not-taken: decrement, 2'b00 holds
REQ-015 In MODE 0 the table SHALL never be updated after INIT.
REQ-016 A same-cycle lookup and update of the same index SHALL read the pre-update counter value (read-before-write).
REQ-017 Speculative history: when branchD=1, lookup_en=1 and RUN, GHR SHALL become {GHR[GHR_W-2:0], pred_takeD} at the next edge.
REQ-018 Repair: when resolve_valid=1 and resolve_mispredict=1, GHR SHALL become {resolve_ghr[GHR_W-2:0], resolve_take}.
REQ-019 Repair SHALL take priority over a same-cycle speculative shift; the shift SHALL be discarded.
REQ-020 A correctly predicted resolve SHALL NOT modify GHR.
REQ-021 GHR SHALL be maintained in all modes but SHALL affect indexing only in MODE 2.

Reset
REQ-022 rst=1 at any edge, including mid-INIT or mid-RUN, SHALL at the next edge:
- enter INIT with the sweep pointer at 0
- clear GHR, pred_takeD, pred_idxD and pred_ghrD to 0
- drive ready to 0
REQ-023 While rst=1 the sweep SHALL NOT advance; INIT SHALL begin on the first edge with rst=0, and ready SHALL rise exactly PHT_DEPTH cycles after rst deasserts.
REQ-024 Counters SHALL NOT be reset directly; their initial value SHALL come only from the INIT sweep.

Verification
REQ-025 Init: PHT_DEPTH=256, deassert rst -> ready=0 for 256 cycles, 1 on cycle 256; every lookup then returns pred_takeD=0.
REQ-026 Bimodal saturation: two taken resolves to idx 4, then lookup pcF=0x00400010 -> pred_takeD=1, pred_idxD=4. Three not-taken resolves -> counter 00, pred 0. A fourth not-taken -> stays 00. One taken -> 01, pred still 0.
REQ-027 Gshare repair: GHR=8'h3C; branchD with pred 1 and a mispredict (resolve_ghr=8'h05, take=1) in the same cycle -> GHR=8'h0B next cycle, the shift to 8'h79 discarded.
REQ-028 Stall/flush: lookup_en=0 for 3 cycles while pcF changes -> D outputs constant. Then flushD=1 with lookup_en=1 -> all D outputs 0.
REQ-029 Reset mid-run: rst pulsed after a trained counter reads 11 -> ready drops, sweep reruns, and the same lookup returns pred 0 once ready=1.
REQ-030 MODE 0: taken resolves to every index -> pred_takeD stays 0 and pred_idxD stays 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direction predictor for the D stage: static not-taken, bimodal or gshare over a table
// of 2-bit saturating counters, swept to weakly-not-taken after reset before use.
module branch_predictor #(
    parameter int PHT_DEPTH = 256,
    parameter int GHR_W     = 8,
    parameter int MODE      = 1,
    localparam int IDX_W    = $clog2(PHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pcF,
    input  logic             lookup_en,
    input  logic             flushD,
    input  logic             branchD,
    input  logic             resolve_valid,
    input  logic [IDX_W-1:0] resolve_idx,
    input  logic [GHR_W-1:0] resolve_ghr,
    input  logic             resolve_take,
    input  logic             resolve_mispredict,
    output logic             ready,
    output logic             pred_takeD,
    output logic [IDX_W-1:0] pred_idxD,
    output logic [GHR_W-1:0] pred_ghrD
);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic             pred_take_q, pred_take_d;
    logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
    logic [GHR_W-1:0] pred_ghr_q, pred_ghr_d;
    logic [1:0]       pht_q [PHT_DEPTH];

    logic             running;
    logic [IDX_W-1:0] pc_idx, ghr_ext, lkp_idx;
    logic [1:0]       lkp_ctr;
    logic             lkp_take;
    logic             upd_en;
    logic             unused_pc_bits;

    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic take);
        if (take)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Oldest history bit falls off the top; the new outcome enters at bit 0.
    function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] h, input logic b);
        return (h << 1) | GHR_W'(b);
    endfunction

    assign running        = (state_q == S_RUN);
    assign unused_pc_bits = ^{pcF[31:IDX_W+2], pcF[1:0]};

    always_comb begin
        pc_idx               = pcF[IDX_W+1:2];
        ghr_ext              = '0;
        ghr_ext[GHR_W-1:0]   = ghr_q;
        if (MODE == 2)
            lkp_idx = pc_idx ^ ghr_ext;
        else if (MODE == 1)
            lkp_idx = pc_idx;
        else
            lkp_idx = '0;
    end

    // Combinational read of the registered table gives read-before-write on a same-index update.
    assign lkp_ctr  = pht_q[lkp_idx];
    assign lkp_take = (MODE != 0) && running && lkp_ctr[1];
    assign upd_en   = (MODE != 0) && running && resolve_valid;

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        ghr_d       = ghr_q;
        pred_take_d = pred_take_q;
        pred_idx_d  = pred_idx_q;
        pred_ghr_d  = pred_ghr_q;

        if (state_q == S_INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == IDX_W'(PHT_DEPTH - 1))
                state_d = S_RUN;
        end else begin
            // A misprediction repair overrides any same-cycle speculative shift.
            if (resolve_valid && resolve_mispredict)
                ghr_d = ghr_shift(resolve_ghr, resolve_take);
            else if (branchD && lookup_en)
                ghr_d = ghr_shift(ghr_q, pred_take_q);
        end

        if (flushD) begin
            pred_take_d = 1'b0;
            pred_idx_d  = '0;
            pred_ghr_d  = '0;
        end else if (lookup_en) begin
            pred_take_d = lkp_take;
            pred_idx_d  = lkp_idx;
            pred_ghr_d  = ghr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            sweep_q     <= '0;
            ghr_q       <= '0;
            pred_take_q <= 1'b0;
            pred_idx_q  <= '0;
            pred_ghr_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            ghr_q       <= ghr_d;
            pred_take_q <= pred_take_d;
            pred_idx_q  <= pred_idx_d;
            pred_ghr_q  <= pred_ghr_d;
        end
    end

    // Counters carry no reset; the INIT sweep is their only initialisation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT)
                pht_q[sweep_q] <= 2'b01;
            else if (upd_en)
                pht_q[resolve_idx] <= sat_update(pht_q[resolve_idx], resolve_take);
        end
    end

    assign ready      = running;
    assign pred_takeD = pred_take_q;
    assign pred_idxD  = pred_idx_q;
    assign pred_ghrD  = pred_ghr_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: three instances (MODE 0/1/2) share stimulus and are checked
// every cycle against an array-based model, plus literal checks of the key scenarios.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        lookup_en, flushD, branchD;
    logic        resolve_valid, resolve_take, resolve_mispredict;
    logic [7:0]  resolve_idx, resolve_ghr;

    logic        rdy_w [3];
    logic        pt_w  [3];
    logic [7:0]  pi_w  [3];
    logic [7:0]  pg_w  [3];

    int n_cmp = 0;
    int n_bad = 0;

    branch_predictor #(.PHT_DEPTH(256), .GHR_W(8), .MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .pcF(pcF), .lookup_en(lookup_en), .flushD(flushD),
        .branchD(branchD), .resolve_valid(resolve_valid), .resolve_idx(resolve_idx),
        .resolve_ghr(resolve_ghr), .resolve_take(resolve_take),
        .resolve_mispredict(resolve_mispredict), .ready(rdy_w[0]),
        .pred_takeD(pt_w[0]), .pred_idxD(pi_w[0]), .pred_ghrD(pg_w[0]));

    branch_predictor #(.PHT_DEPTH(256), .GHR_W(8), .MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .pcF(pcF), .lookup_en(lookup_en), .flushD(flushD),
        .branchD(branchD), .resolve_valid(resolve_valid), .resolve_idx(resolve_idx),
        .resolve_ghr(resolve_ghr), .resolve_take(resolve_take),
        .resolve_mispredict(resolve_mispredict), .ready(rdy_w[1]),
        .pred_takeD(pt_w[1]), .pred_idxD(pi_w[1]), .pred_ghrD(pg_w[1]));

    branch_predictor #(.PHT_DEPTH(256), .GHR_W(8), .MODE(2)) u_m2 (
        .clk(clk), .rst(rst), .pcF(pcF), .lookup_en(lookup_en), .flushD(flushD),
        .branchD(branchD), .resolve_valid(resolve_valid), .resolve_idx(resolve_idx),
        .resolve_ghr(resolve_ghr), .resolve_take(resolve_take),
        .resolve_mispredict(resolve_mispredict), .ready(rdy_w[2]),
        .pred_takeD(pt_w[2]), .pred_idxD(pi_w[2]), .pred_ghrD(pg_w[2]));

    always #5 clk = ~clk;

    // Behavioural model: one counter table, history and D-output set per mode.
    int m_valid = 0;
    int m_init  = 1;
    int m_sweep = 0;
    int m_cnt [3][256];
    int m_ghr [3];
    int m_pt  [3];
    int m_pi  [3];
    int m_pg  [3];

    task automatic model_step();
        int idx, npt, oldpt, oldghr, pcidx;
        if (rst) begin
            m_valid = 1;
            m_init  = 1;
            m_sweep = 0;
            for (int m = 0; m < 3; m++) begin
                m_ghr[m] = 0; m_pt[m] = 0; m_pi[m] = 0; m_pg[m] = 0;
            end
        end else if (m_valid != 0) begin
            pcidx = int'((pcF >> 2) & 32'hFF);
            for (int m = 0; m < 3; m++) begin
                oldghr = m_ghr[m];
                oldpt  = m_pt[m];
                if (m == 0)      idx = 0;
                else if (m == 1) idx = pcidx;
                else             idx = pcidx ^ oldghr;
                npt = (m_init != 0 || m == 0) ? 0 : ((m_cnt[m][idx] >= 2) ? 1 : 0);
                if (m_init == 0) begin
                    if (resolve_valid && m != 0) begin
                        if (resolve_take) begin
                            if (m_cnt[m][resolve_idx] < 3) m_cnt[m][resolve_idx]++;
                        end else begin
                            if (m_cnt[m][resolve_idx] > 0) m_cnt[m][resolve_idx]--;
                        end
                    end
                    if (resolve_valid && resolve_mispredict)
                        m_ghr[m] = (int'(resolve_ghr) * 2 + int'(resolve_take)) % 256;
                    else if (branchD && lookup_en)
                        m_ghr[m] = (oldghr * 2 + oldpt) % 256;
                end
                if (flushD) begin
                    m_pt[m] = 0; m_pi[m] = 0; m_pg[m] = 0;
                end else if (lookup_en) begin
                    m_pt[m] = npt; m_pi[m] = idx; m_pg[m] = oldghr;
                end
            end
            if (m_init != 0) begin
                for (int m = 0; m < 3; m++) m_cnt[m][m_sweep] = 1;
                if (m_sweep == 255) m_init = 0;
                m_sweep++;
            end
        end
    endtask

    task automatic cmp(input string nm, input int m, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL model %s mode%0d: got %0h, expected %0h at %0t", nm, m, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 3; m++) begin
            cmp("ready",      m, 32'(rdy_w[m]), (m_init != 0) ? 32'd0 : 32'd1);
            cmp("pred_takeD", m, 32'(pt_w[m]),  32'(m_pt[m]));
            cmp("pred_idxD",  m, 32'(pi_w[m]),  32'(m_pi[m]));
            cmp("pred_ghrD",  m, 32'(pg_w[m]),  32'(m_pg[m]));
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_valid != 0) compare_all();
    endtask

    task automatic idle();
        rst = 1'b0; lookup_en = 1'b0; flushD = 1'b0; branchD = 1'b0;
        resolve_valid = 1'b0; resolve_take = 1'b0; resolve_mispredict = 1'b0;
        resolve_idx = 8'd0; resolve_ghr = 8'd0;
    endtask

    task automatic rand_inputs();
        rst                = 1'b0;
        pcF                = 32'h0040_0000 | (32'($urandom_range(0, 63)) << 2);
        lookup_en          = ($urandom_range(0, 3) != 0);
        flushD             = ($urandom_range(0, 15) == 0);
        branchD            = 1'($urandom_range(0, 1));
        resolve_valid      = 1'($urandom_range(0, 1));
        resolve_idx        = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
        resolve_ghr        = 8'($urandom);
        resolve_take       = 1'($urandom_range(0, 1));
        resolve_mispredict = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    localparam logic [11:0] P3_RV   = 12'b1101_1101_1010;
    localparam logic [11:0] P3_TAKE = 12'b1100_0000_1010;
    localparam logic [11:0] P3_EXP  = 12'b0111_1000_0001;

    initial begin
        int n;
        logic [11:0] rv_v, tk_v, ex_v;
        idle();
        pcF = 32'h0;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_ready", 32'(rdy_w[1]), 32'd0);
        chk("reset_take",  32'(pt_w[1]),  32'd0);
        chk("reset_idx",   32'(pi_w[1]),  32'd0);
        chk("reset_ghr",   32'(pg_w[2]),  32'd0);

        // Init sweep with random traffic that must all be ignored.
        for (int i = 1; i <= 256; i++) begin
            rand_inputs();
            tick();
            if (i == 255) chk("init_ready_255", 32'(rdy_w[1]), 32'd0);
            if (i == 256) chk("init_ready_256", 32'(rdy_w[1]), 32'd1);
        end

        idle();
        for (int i = 0; i < 8; i++) begin
            pcF = 32'h0040_0000 | (32'($urandom_range(0, 255)) << 2);
            lookup_en = 1'b1;
            tick();
            chk("post_init_pred0", 32'(pt_w[1]), 32'd0);
        end

        // Bimodal saturation on index 4 with same-cycle lookups (pre-update values).
        rv_v = P3_RV; tk_v = P3_TAKE; ex_v = P3_EXP;
        for (int i = 0; i < 12; i++) begin
            idle();
            pcF = 32'h0040_0010;
            lookup_en = 1'b1;
            resolve_valid = rv_v[11 - i];
            resolve_take = tk_v[11 - i];
            resolve_idx = 8'd4;
            tick();
            chk($sformatf("bimodal_step%0d", i), 32'(pt_w[1]), 32'(ex_v[11 - i]));
            if (i == 2) chk("bimodal_idx", 32'(pi_w[1]), 32'd4);
        end

        // Gshare repair beats a same-cycle speculative shift.
        idle(); pcF = 32'h0040_0010; lookup_en = 1'b1;
        tick();
        chk("gs_pred1", 32'(pt_w[2]), 32'd1);
        idle(); resolve_valid = 1'b1; resolve_mispredict = 1'b1;
        resolve_ghr = 8'h1E; resolve_take = 1'b0; resolve_idx = 8'd200;
        tick();
        idle(); pcF = 32'h0040_0010; lookup_en = 1'b1; branchD = 1'b1;
        resolve_valid = 1'b1; resolve_mispredict = 1'b1;
        resolve_ghr = 8'h05; resolve_take = 1'b1; resolve_idx = 8'd200;
        tick();
        chk("gs_ghr_3C", 32'(pg_w[2]), 32'h3C);
        chk("gs_idx_38", 32'(pi_w[2]), 32'h38);
        idle(); pcF = 32'h0040_0010; lookup_en = 1'b1;
        tick();
        chk("gs_ghr_0B", 32'(pg_w[2]), 32'h0B);
        chk("gs_idx_0F", 32'(pi_w[2]), 32'h0F);

        // Stall holds D outputs; flush clears them even with lookup_en.
        for (int i = 0; i < 3; i++) begin
            idle(); pcF = 32'h0040_0000 | (32'($urandom_range(0, 255)) << 2);
            tick();
            chk("stall_take", 32'(pt_w[1]), 32'd1);
            chk("stall_idx",  32'(pi_w[1]), 32'd4);
            chk("stall_ghr",  32'(pg_w[1]), 32'h0B);
        end
        idle(); flushD = 1'b1; lookup_en = 1'b1; pcF = 32'h0040_0010;
        tick();
        chk("flush_take", 32'(pt_w[1]), 32'd0);
        chk("flush_idx",  32'(pi_w[1]), 32'd0);
        chk("flush_ghr",  32'(pg_w[2]), 32'd0);

        // Train to 11, reset mid-run, and confirm the sweep restores weakly-not-taken.
        idle(); resolve_valid = 1'b1; resolve_take = 1'b1; resolve_idx = 8'd4;
        tick();
        idle(); pcF = 32'h0040_0010; lookup_en = 1'b1;
        tick();
        chk("trained_pred1", 32'(pt_w[1]), 32'd1);
        idle(); rst = 1'b1;
        tick();
        chk("rst_ready0", 32'(rdy_w[1]), 32'd0);
        chk("rst_take0",  32'(pt_w[1]),  32'd0);
        idle();
        n = 0;
        while (rdy_w[1] !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("rst_ready_latency", 32'(n), 32'd256);
        idle(); pcF = 32'h0040_0010; lookup_en = 1'b1;
        tick();
        chk("rst_pred0", 32'(pt_w[1]), 32'd0);

        // Taken resolve to every index: MODE 0 must stay static.
        for (int i = 0; i < 256; i++) begin
            idle(); resolve_valid = 1'b1; resolve_take = 1'b1; resolve_idx = 8'(i);
            lookup_en = 1'b1; pcF = 32'h0040_0000 + 32'(i * 4);
            tick();
        end
        chk("mode0_take", 32'(pt_w[0]), 32'd0);
        chk("mode0_idx",  32'(pi_w[0]), 32'd0);
        idle(); lookup_en = 1'b1; pcF = 32'h0040_0024;
        tick();
        chk("sweep_trained_pred", 32'(pt_w[1]), 32'd1);
        chk("sweep_trained_idx",  32'(pi_w[1]), 32'd9);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
